// File: rtl/xbus_arbiter_pkg.sv
// xbus_arbiter_pkg
// Shared definitions for the two-master bus arbiter: bus widths, FSM state
// encodings and the bound on consecutive locked accesses.
package xbus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    XBUS_IDLE   = 2'd0,
    XBUS_ACCESS = 2'd1,
    XBUS_RESP   = 2'd2
  } xbus_state_e;

  localparam int XBUS_LOCK_MAX = 8;

endpackage

// File: rtl/xarb_rr_pick.sv
// xarb_rr_pick
// Combinational round-robin picker for two requesters.
// Ports:
//   req[1:0]   request vector (bit k = master k)
//   last_gnt   master granted most recently
//   gnt_valid  at least one request present
//   gnt_id     chosen master; on a tie, the one not granted last
module xarb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;

  always_comb begin
    if (req == 2'b11) gnt_id = ~last_gnt;
    else              gnt_id = req[1];
  end

endmodule

// File: rtl/xbus_arbiter.sv
// xbus_arbiter
// Shares one memory-mapped bus between master 0 (processor) and master 1
// (external/debug port). One access at a time: IDLE -> ACCESS -> RESP.
// Decoder inputs are driven for exactly the ACCESS cycle; read data and trap
// are registered at the end of ACCESS and returned with the ack in RESP.
// Optional macro: XBUS_ARB_LOCK_EN enables bounded grant locking
// (RESP -> ACCESS for the same master, at most XBUS_LOCK_MAX in a row).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mK_req/addr/we/wdata/lock     master K request side
//   mK_ack/rdata/err              master K response side
//   bus_addr/sel/we/wdata         to decoder / slaves
//   bus_rdata, bus_trap           from decoder
module xbus_arbiter
  import xbus_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_sel,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_trap
);

  xbus_state_e       state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_gnt_q;
  logic              err_cap_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic              pick_valid, pick_id;
  logic              lock_go;

  xarb_rr_pick u_pick (
    .req       ({m1_req, m0_req}),
    .last_gnt  (last_gnt_q),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

`ifdef XBUS_ARB_LOCK_EN
  localparam logic [2:0] LOCK_LAST = 3'(XBUS_LOCK_MAX - 1);
  logic [2:0] lock_cnt_q;
  logic       gnt_req, gnt_lock;

  assign gnt_req  = gnt_q ? m1_req  : m0_req;
  assign gnt_lock = gnt_q ? m1_lock : m0_lock;
  // lock_cnt_q counts locked re-grants already taken in this run, so the
  // run is at most XBUS_LOCK_MAX accesses including the first one.
  assign lock_go  = (state_q == XBUS_RESP) && gnt_req && gnt_lock &&
                    (lock_cnt_q != LOCK_LAST);

  always_ff @(posedge clk) begin
    if (rst)                      lock_cnt_q <= '0;
    else if (state_q == XBUS_RESP) lock_cnt_q <= lock_go ? lock_cnt_q + 3'd1 : '0;
  end
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
  assign lock_go     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= XBUS_IDLE;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      XBUS_IDLE: begin
        if (pick_valid) begin
          state_d = XBUS_ACCESS;
          gnt_d   = pick_id;
        end
      end
      XBUS_ACCESS: state_d = XBUS_RESP;
      XBUS_RESP:   state_d = lock_go ? XBUS_ACCESS : XBUS_IDLE;
      default:     state_d = XBUS_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus_sel   = 1'b0;
    bus_addr  = '0;
    bus_we    = 1'b0;
    bus_wdata = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    if (state_q == XBUS_ACCESS) begin
      bus_sel   = 1'b1;
      bus_addr  = gnt_q ? m1_addr  : m0_addr;
      bus_we    = gnt_q ? m1_we    : m0_we;
      bus_wdata = gnt_q ? m1_wdata : m0_wdata;
    end
    if (state_q == XBUS_RESP) begin
      m0_ack = ~gnt_q;
      m1_ack =  gnt_q;
      m0_err = ~gnt_q & err_cap_q;
      m1_err =  gnt_q & err_cap_q;
    end
  end

  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

  // Capture registers; rdata is kept per master so it holds across the
  // other master's accesses. last_gnt only moves when a run ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cap_q  <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      if (state_q == XBUS_ACCESS) begin
        err_cap_q <= bus_trap;
        if (gnt_q) m1_rdata_q <= bus_rdata;
        else       m0_rdata_q <= bus_rdata;
      end
      if ((state_q == XBUS_RESP) && !lock_go) last_gnt_q <= gnt_q;
    end
  end

endmodule
